// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit.
// Sequences program loading (IDLE -> LOAD -> RUN), fetches one word per cycle
// from instruction memory into a 2-entry {word, PC} buffer feeding decode, and
// handles redirects, halt words and program reloads.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        programLoaded,
    input  logic [31:0] fullInstruction,
    output logic        startProgramLoading,
    output logic [31:0] fromPC,
    input  logic        redirectValid,
    input  logic [31:0] redirectTarget,
    input  logic        decodeReady,
    output logic        instrValid,
    output logic [31:0] instrOut,
    output logic [31:0] instrPC,
    output logic [1:0]  fetchState,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    // Buffer storage: circular, head index plus occupancy count.
    logic [31:0] r_word     [2];
    logic [31:0] r_entry_pc [2];
    logic        r_head;
    logic        w_head_next;
    logic [1:0]  r_count;
    logic [1:0]  w_count_next;

    logic        w_valid;
    logic        w_pop;
    logic [1:0]  w_count_after_pop;
    logic        w_has_space;
    logic        w_is_halt_word;
    logic        w_push;
    logic        w_push_idx;
    logic [31:0] w_redirect_pc;

    // Buffer status and helper terms shared by the next-state logic.
    always_comb begin
        w_valid           = (r_count != 2'd0);
        w_pop             = w_valid && decodeReady;
        w_count_after_pop = r_count - {1'b0, w_pop};
        w_has_space       = (w_count_after_pop != 2'd2);
        w_is_halt_word    = (fullInstruction == HALT_WORD);
        // Tail slot is head+count; on a full buffer that is the slot being
        // popped this edge, which is exactly where the new entry belongs.
        w_push_idx        = r_head ^ r_count[0];
        // Redirect targets are forced to word alignment.
        w_redirect_pc     = redirectTarget & 32'hFFFF_FFFC;
    end

    // Next-state, next-PC and buffer bookkeeping; redirect beats every other event.
    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_head_next         = r_head;
        w_count_next        = r_count;
        w_push              = 1'b0;
        startProgramLoading = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                startProgramLoading = 1'b1;
                if (programLoaded) begin
                    w_state_next = S_RUN;
                    w_pc_next    = RESET_PC;
                end
            end
            S_RUN, S_HALT: begin
                if (redirectValid) begin
                    w_state_next = S_RUN;
                    w_pc_next    = w_redirect_pc;
                    w_head_next  = 1'b0;
                    w_count_next = 2'd0;
                end else if (!programLoaded) begin
                    w_state_next = S_LOAD;
                    w_head_next  = 1'b0;
                    w_count_next = 2'd0;
                end else begin
                    w_head_next  = r_head ^ w_pop;
                    w_count_next = w_count_after_pop;
                    if ((r_state == S_RUN) && w_has_space) begin
                        if (w_is_halt_word) begin
                            w_state_next = S_HALT;
                        end else begin
                            w_push       = 1'b1;
                            w_count_next = w_count_after_pop + 2'd1;
                            w_pc_next    = r_pc + 32'd4;
                        end
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, PC and buffer registers; reset empties the buffer at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_word[i]     <= 32'd0;
                r_entry_pc[i] <= 32'd0;
            end
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_head  <= w_head_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_word[w_push_idx]     <= fullInstruction;
                r_entry_pc[w_push_idx] <= r_pc;
            end
        end
    end

    // Head presentation; outputs read as zero while the buffer is empty.
    always_comb begin
        instrValid = w_valid;
        instrOut   = w_valid ? r_word[r_head]     : 32'd0;
        instrPC    = w_valid ? r_entry_pc[r_head] : 32'd0;
        fromPC     = r_pc;
        fetchState = r_state;
        halted     = (r_state == S_HALT);
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        programLoaded = 1'b0;
    logic [31:0] fullInstruction;
    logic        startProgramLoading;
    logic [31:0] fromPC;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectTarget = 32'd0;
    logic        decodeReady = 1'b1;
    logic        instrValid;
    logic [31:0] instrOut;
    logic [31:0] instrPC;
    logic [1:0]  fetchState;
    logic        halted;

    // 64-word instruction memory, wrapped on address bits [7:2].
    logic [31:0] mem [64];
    assign fullInstruction = mem[fromPC[7:2]];

    instruction_fetch_unit dut (
        .clock               (clock),
        .reset               (reset),
        .programLoaded       (programLoaded),
        .fullInstruction     (fullInstruction),
        .startProgramLoading (startProgramLoading),
        .fromPC              (fromPC),
        .redirectValid       (redirectValid),
        .redirectTarget      (redirectTarget),
        .decodeReady         (decodeReady),
        .instrValid          (instrValid),
        .instrOut            (instrOut),
        .instrPC             (instrPC),
        .fetchState          (fetchState),
        .halted              (halted)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: state number, fetch address, queue of {word, pc}.
    int          m_state;
    logic [31:0] m_pc;
    logic [63:0] m_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'd0;
        m_q.delete();
    endtask

    // One rising edge of the reference behaviour, using the inputs held since the last negedge.
    task automatic model_step();
        logic [31:0] w;
        if (!reset) begin
            model_reset();
            return;
        end
        case (m_state)
            0: m_state = 1;
            1: if (programLoaded) begin
                   m_state = 2;
                   m_pc    = 32'd0;
               end
            default: begin
                if (redirectValid) begin
                    m_q.delete();
                    m_pc    = redirectTarget & ~32'd3;
                    m_state = 2;
                end else if (!programLoaded) begin
                    m_q.delete();
                    m_state = 1;
                end else begin
                    if (m_q.size() > 0 && decodeReady) void'(m_q.pop_front());
                    if (m_state == 2 && m_q.size() < 2) begin
                        w = mem[m_pc[7:2]];
                        if (w == 32'd0) begin
                            m_state = 3;
                        end else begin
                            m_q.push_back({w, m_pc});
                            m_pc = m_pc + 32'd4;
                        end
                    end
                end
            end
        endcase
    endtask

    // Compare every DUT output against the model.
    task automatic compare_model();
        logic [31:0] e_word;
        logic [31:0] e_pc;
        e_word = (m_q.size() > 0) ? m_q[0][63:32] : 32'd0;
        e_pc   = (m_q.size() > 0) ? m_q[0][31:0]  : 32'd0;
        chk("instrValid", 32'(instrValid), 32'(m_q.size() > 0));
        chk("instrOut", instrOut, e_word);
        chk("instrPC", instrPC, e_pc);
        chk("fromPC", fromPC, m_pc);
        chk("fetchState", 32'(fetchState), m_state);
        chk("halted", 32'(halted), 32'(m_state == 3));
        chk("startProgramLoading", 32'(startProgramLoading), 32'(m_state == 1));
        $display("cyc=%0d st=%0d fromPC=%h valid=%b instrPC=%h instr=%h",
                 cyc, fetchState, fromPC, instrValid, instrPC, instrOut);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        cyc++;
        compare_model();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom | 32'h0000_0001;
        end
        mem[0] = 32'h201d_0100;
        mem[1] = 32'h2010_000c;
        mem[2] = 32'hafb0_0000;
        mem[3] = 32'h8c08_0004;
        mem[4] = 32'h0000_0000;
        model_reset();

        // Reset state
        #1;
        chk("rst_state", 32'(fetchState), 32'd0);
        chk("rst_fromPC", fromPC, 32'd0);
        chk("rst_valid", 32'(instrValid), 32'd0);
        chk("rst_instrOut", instrOut, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // IDLE -> LOAD, wait for load completion
        tick();
        chk("load_start", 32'(startProgramLoading), 32'd1);
        chk("load_state", 32'(fetchState), 32'd1);
        repeat (4) tick();
        chk("load_start_held", 32'(startProgramLoading), 32'd1);
        programLoaded = 1'b1;
        tick();
        chk("run_state", 32'(fetchState), 32'd2);
        chk("run_start_low", 32'(startProgramLoading), 32'd0);
        chk("run_valid0", 32'(instrValid), 32'd0);

        // Streaming with decode always ready
        tick();
        chk("seq0_pc", instrPC, 32'd0);
        chk("seq0_word", instrOut, 32'h201d_0100);
        tick();
        chk("seq1_pc", instrPC, 32'd4);
        chk("seq1_word", instrOut, 32'h2010_000c);
        tick();
        chk("seq2_pc", instrPC, 32'd8);
        chk("seq2_word", instrOut, 32'hafb0_0000);

        // Back-pressure saturates the buffer
        decodeReady = 1'b0;
        repeat (4) tick();
        chk("stall_fromPC", fromPC, 32'd16);
        chk("stall_head", instrPC, 32'd8);

        // Halt word at PC 16; buffered entries keep draining
        decodeReady = 1'b1;
        tick();
        chk("halt_state", 32'(fetchState), 32'd3);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_fromPC", fromPC, 32'd16);
        chk("halt_drain_pc", instrPC, 32'd12);
        tick();
        chk("halt_empty", 32'(instrValid), 32'd0);

        // Redirect to 0 resumes
        redirectValid = 1'b1;
        redirectTarget = 32'd0;
        tick();
        redirectValid = 1'b0;
        chk("resume_state", 32'(fetchState), 32'd2);
        decodeReady = 1'b0;
        repeat (3) tick();
        chk("full_fromPC", fromPC, 32'd8);
        chk("full_head", instrPC, 32'd0);

        // Redirect on a full buffer to an unaligned target
        redirectValid = 1'b1;
        redirectTarget = 32'h0000_002E;
        tick();
        redirectValid = 1'b0;
        chk("redir_flush", 32'(instrValid), 32'd0);
        chk("redir_fromPC", fromPC, 32'h0000_002C);
        tick();
        chk("redir_head", instrPC, 32'h0000_002C);

        // PC wraps modulo 2^32
        decodeReady = 1'b1;
        redirectValid = 1'b1;
        redirectTarget = 32'hFFFF_FFFC;
        tick();
        redirectValid = 1'b0;
        tick();
        chk("wrap_head", instrPC, 32'hFFFF_FFFC);
        chk("wrap_fromPC", fromPC, 32'd0);

        // Asynchronous reset with a full buffer
        decodeReady = 1'b0;
        repeat (2) tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 32'(instrValid), 32'd0);
        chk("arst_fromPC", fromPC, 32'd0);
        chk("arst_state", 32'(fetchState), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        decodeReady = 1'b1;
        tick();
        tick();
        chk("rerun_state", 32'(fetchState), 32'd2);

        // Randomized traffic
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom | 32'h0000_0001;
            if ($urandom_range(0, 19) == 0) mem[i] = 32'd0;
        end
        for (int n = 0; n < 2000; n++) begin
            decodeReady   = ($urandom_range(0, 3) != 0);
            redirectValid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0)
                redirectTarget = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                redirectTarget = 32'($urandom_range(0, 255));
            if (programLoaded)
                programLoaded = ($urandom_range(0, 99) != 0);
            else
                programLoaded = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b0;
                model_reset();
                #1 compare_model();
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: first fetch byte address after load completes.
REQ-002 Parameter HALT_WORD, default 32'h00000000: fetched word that stops fetching.
REQ-003 Port clock  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: one clock; reset is asynchronous and active-low.
REQ-005 Port programLoaded  input  1: instruction memory load complete, level.
REQ-006 Port fullInstruction  input  32: memory word for fromPC, valid before the next rising edge.
REQ-007 Port startProgramLoading  output  1: request to instruction memory to begin loading.
REQ-008 Port fromPC  output  32: byte address presented to instruction memory, registered.
REQ-009 Port redirectValid  input  1: branch/jump redirect request, one-cycle pulse.
REQ-010 Port redirectTarget  input  32: redirect byte address.
REQ-011 Port decodeReady  input  1: decode stage accepts the head entry this cycle.
REQ-012 Port instrValid  output  1: buffer non-empty; head entry presented.
REQ-013 Port instrOut  output  32: head instruction word.
REQ-014 Port instrPC  output  32: byte address of head instruction.
REQ-015 Port fetchState  output  2: IDLE=0, LOAD=1, RUN=2, HALT=3.
REQ-016 Port halted  output  1: high exactly when fetchState==HALT.

Function
REQ-017 FSM SHALL leave IDLE for LOAD unconditionally on the first rising edge after reset deasserts.
REQ-018 startProgramLoading SHALL be 1 only in LOAD; LOAD -> RUN when programLoaded==1, with fromPC <= RESET_PC.
REQ-019 2-entry FIFO of {word, PC}; instrValid = count!=0; instrOut/instrPC = head; pop when instrValid && decodeReady.
REQ-020 In RUN without redirect: at each edge, if FIFO has space after that edge's pop, fullInstruction is pushed with PC=fromPC and fromPC <= fromPC+4; otherwise fromPC holds and nothing is pushed.
REQ-021 Fetch-to-instrValid latency SHALL be 1 cycle; sustained throughput 1 instruction/cycle while decodeReady is held high.
REQ-022 Simultaneous pop and push on a full FIFO SHALL succeed (count unchanged, order preserved).
REQ-023 fromPC addition SHALL be 32-bit modulo; 32'hFFFFFFFC + 4 wraps to 0.
REQ-024 redirectValid in RUN or HALT: FIFO flushed (count=0, pop ignored), no push, fromPC <= {redirectTarget[31:2],2'b00}, state -> RUN; redirect has priority over every other event that edge.
REQ-025 redirectValid in IDLE or LOAD SHALL be ignored.
REQ-026 In RUN, a push candidate equal to HALT_WORD SHALL NOT be pushed; fromPC holds and state -> HALT.
REQ-027 In HALT, no fetches occur; fromPC holds; FIFO continues draining to decode.
REQ-028 programLoaded falling to 0 in RUN or HALT: FIFO flushed, state -> LOAD, fromPC holds.
REQ-029 fetchState SHALL change only on rising edges or asynchronous reset.

Reset
REQ-030 reset low SHALL immediately force: state IDLE, FIFO empty, fromPC=RESET_PC, startProgramLoading=0, instrValid=0, instrOut=0, instrPC=0, halted=0.
REQ-031 reset asserted mid-RUN SHALL discard all buffered instructions; no entry survives reset.
REQ-032 After reset release, the full IDLE -> LOAD -> RUN sequence SHALL repeat.

Verification
REQ-033 Reset release, programLoaded rises 5 cycles later -> startProgramLoading high from cycle 1 to the cycle programLoaded is seen; first instrValid with instrPC=0 one cycle after RUN entry.
REQ-034 RUN, decodeReady=1, memory returns 32'h201d0100, 32'h2010000c, 32'hafb00000 -> instrOut sequence matches, instrPC 0,4,8 on consecutive cycles.
REQ-035 decodeReady=0 for 4 cycles -> count saturates at 2, fromPC stalls at 8; on release, PCs 0,4,8,12 delivered with no gaps or duplicates.
REQ-036 redirectValid with redirectTarget=32'h0000002E while FIFO full -> FIFO empty next cycle, fromPC=32'h0000002C, next instrPC=32'h0000002C.
REQ-037 Word 32'h00000000 at PC 16 -> state HALT, halted=1, fromPC stays 16, entries for PC 8/12 still drain; subsequent redirect to 0 resumes RUN.
REQ-038 reset pulsed low mid-RUN with FIFO full -> instrValid=0 and fromPC=0 immediately, without a clock edge.
